// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM with a fixed-latency response pipeline feeding a credit-protected output FIFO.
// Optional misaligned-access checking is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wr_data,
    input  logic             req_MemWrite,
    input  logic             req_MemRead,
    input  logic [TAG_W-1:0] req_tag,
    output logic             req_ready,
    output logic             resp_valid,
    output logic [31:0]      resp_rd_data,
    output logic             resp_MemWrite,
    output logic             resp_MemRead,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    input  logic             resp_ready
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int FD = LATENCY + 2;
    localparam int PW = $clog2(FD);
    localparam int CW = $clog2(FD + 1);

    typedef struct packed {
        logic             mem_write;
        logic             mem_read;
        logic             err;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } resp_t;

    logic          accept;
    logic [AW-1:0] word_idx;
    logic          addr_err;
    logic          wr_en;
    logic          rd_en;
    logic          unused_addr_bits;

    assign accept   = req_valid && req_ready;
    assign word_idx = req_addr[AW+1:2];

`ifdef DMEM_MISALIGN_CHK_EN
    assign addr_err         = |req_addr[1:0];
    assign unused_addr_bits = ^req_addr[31:AW+2];
`else
    assign addr_err         = 1'b0;
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

    assign wr_en = accept && req_MemWrite && !addr_err;
    assign rd_en = accept && req_MemRead && !addr_err;

    // Memory is deliberately outside reset; read returns pre-edge contents (read-before-write).
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[word_idx] <= req_wr_data;
        end
        rd_data_reg <= mem[word_idx];
    end

    logic [LATENCY:1] pipe_valid_reg;
    resp_t            pipe_reg [1:LATENCY];
    resp_t            pipe_out [1:LATENCY];
    logic             stage1_rd_en_reg;

    // Stage 1 picks up the RAM read data, which only exists one edge after acceptance.
    always_comb begin
        for (int i = 1; i <= LATENCY; i++) begin
            pipe_out[i] = pipe_reg[i];
        end
        pipe_out[1].data = stage1_rd_en_reg ? rd_data_reg : 32'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid_reg   <= '0;
            stage1_rd_en_reg <= 1'b0;
            for (int i = 1; i <= LATENCY; i++) begin
                pipe_reg[i] <= '0;
            end
        end else begin
            pipe_valid_reg[1]     <= accept;
            stage1_rd_en_reg      <= rd_en;
            pipe_reg[1].mem_write <= accept && req_MemWrite;
            pipe_reg[1].mem_read  <= accept && req_MemRead;
            pipe_reg[1].err       <= accept && addr_err;
            pipe_reg[1].tag       <= accept ? req_tag : '0;
            pipe_reg[1].data      <= 32'd0;
            for (int i = 2; i <= LATENCY; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_reg[i]       <= pipe_out[i-1];
            end
        end
    end

    logic [CW-1:0] inflight;
    assign inflight = CW'($countones(pipe_valid_reg));

    resp_t         fifo_mem [FD];
    resp_t         fifo_head;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push;
    logic          pop;

    assign push = pipe_valid_reg[LATENCY];
    assign pop  = resp_valid && resp_ready;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= pipe_out[LATENCY];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Credits come from registered occupancy only, so a pop in this cycle frees a slot next cycle.
    assign req_ready = ((CW+1)'(count_reg) + (CW+1)'(inflight)) < (CW+1)'(FD);

    assign fifo_head     = fifo_mem[rd_ptr_reg];
    assign resp_valid    = (count_reg != '0);
    assign resp_rd_data  = resp_valid ? fifo_head.data : 32'd0;
    assign resp_MemWrite = resp_valid && fifo_head.mem_write;
    assign resp_MemRead  = resp_valid && fifo_head.mem_read;
    assign resp_tag      = resp_valid ? fifo_head.tag : '0;
    assign resp_err      = resp_valid && fifo_head.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a queue-of-responses reference model.
module tb_dmem_responder;

    localparam int L  = 2;
    localparam int TW = 4;
    localparam int FD = L + 2;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic [31:0]   req_addr;
    logic [31:0]   req_wr_data;
    logic          req_MemWrite;
    logic          req_MemRead;
    logic [TW-1:0] req_tag;
    logic          req_ready;
    logic          resp_valid;
    logic [31:0]   resp_rd_data;
    logic          resp_MemWrite;
    logic          resp_MemRead;
    logic [TW-1:0] resp_tag;
    logic          resp_err;
    logic          resp_ready;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(L), .TAG_W(TW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_wr_data(req_wr_data),
        .req_MemWrite(req_MemWrite), .req_MemRead(req_MemRead), .req_tag(req_tag),
        .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rd_data(resp_rd_data),
        .resp_MemWrite(resp_MemWrite), .resp_MemRead(resp_MemRead),
        .resp_tag(resp_tag), .resp_err(resp_err), .resp_ready(resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]   data;
        bit            wr;
        bit            rd;
        bit            err;
        logic [TW-1:0] tag;
        int            vis;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl_mem [256];
    int          total = 0;
    int          bad = 0;
    int          dut_acc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check outputs, drive the next request, then advance the model.
    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                        input bit w, input bit r, input logic [TW-1:0] t, input bit rr);
        bit   mv;
        bit   mr;
        exp_t e;
        int   idx;
        @(negedge clk);
        mv = (q.size() > 0) && (q[0].vis <= cyc);
        mr = (q.size() < FD);
        chk("req_ready", req_ready, mr);
        chk("resp_valid", resp_valid, mv);
        if (mv) begin
            chk("resp_rd_data", resp_rd_data, q[0].data);
            chk("resp_MemWrite", resp_MemWrite, q[0].wr);
            chk("resp_MemRead", resp_MemRead, q[0].rd);
            chk("resp_tag", resp_tag, q[0].tag);
            chk("resp_err", resp_err, q[0].err);
        end
        if (req_ready && v) dut_acc++;
        req_valid    = v;
        req_addr     = a;
        req_wr_data  = d;
        req_MemWrite = w;
        req_MemRead  = r;
        req_tag      = t;
        resp_ready   = rr;
        if (mv && rr) void'(q.pop_front());
        if (v && mr && reset_n) begin
            idx = int'(a[9:2]);
`ifdef DMEM_MISALIGN_CHK_EN
            e.err = (a[1:0] != 2'b00);
`else
            e.err = 1'b0;
`endif
            e.data = (r && !e.err) ? mdl_mem[idx] : 32'd0;
            if (w && !e.err) mdl_mem[idx] = d;
            e.wr  = w;
            e.rd  = r;
            e.tag = t;
            e.vis = cyc + 1 + L;
            q.push_back(e);
        end
    endtask

    task automatic idle(input bit rr);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, '0, rr);
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && q.size() > 0; k++) idle(1'b1);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rd_data", resp_rd_data, 0);
        chk("rst_MemWrite", resp_MemWrite, 0);
        chk("rst_MemRead", resp_MemRead, 0);
        chk("rst_tag", resp_tag, 0);
        chk("rst_err", resp_err, 0);
        q.delete();
        idle(1'b0);
        idle(1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    int a0;

    initial begin
        reset_n = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_wr_data = '0;
        req_MemWrite = 1'b0; req_MemRead = 1'b0; req_tag = '0; resp_ready = 1'b0;
        do_reset();

        // Give every word a known value so later reads have a defined expectation.
        for (int i = 0; i < 256; i++)
            step(1'b1, 32'(i * 4), $urandom, 1'b1, 1'b0, TW'(i), 1'b1);
        drain();

        // Write then read the same word on the next cycle.
        step(1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 1'b0, 4'd1, 1'b1);
        step(1'b1, 32'h40, 32'd0, 1'b0, 1'b1, 4'd2, 1'b1);
        drain();

        // Back-to-back reads.
        a0 = dut_acc;
        for (int i = 0; i < 8; i++)
            step(1'b1, 32'(i * 4), 32'd0, 1'b0, 1'b1, TW'(i), 1'b1);
        chk("b2b_accepts", dut_acc - a0, 8);
        drain();

        // Backpressure: only FD requests fit, one pop frees one credit.
        a0 = dut_acc;
        for (int i = 0; i < 8; i++)
            step(1'b1, 32'(i * 4), 32'd0, 1'b0, 1'b1, TW'(i), 1'b0);
        chk("bp_accepts", dut_acc - a0, FD);
        idle(1'b1);
        step(1'b1, 32'h20, 32'd0, 1'b0, 1'b1, 4'd9, 1'b0);
        idle(1'b0);
        drain();

        // Reset mid-flight drops responses but keeps memory.
        step(1'b1, 32'h80, 32'h12345678, 1'b1, 1'b0, 4'd3, 1'b1);
        drain();
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'(i * 4), 32'd0, 1'b0, 1'b1, TW'(i), 1'b1);
        idle(1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) idle(1'b1);
        step(1'b1, 32'h80, 32'd0, 1'b0, 1'b1, 4'd4, 1'b1);
        drain();

        // Read-modify-write returns the old word.
        step(1'b1, 32'h10, 32'h11111111, 1'b1, 1'b0, 4'd5, 1'b1);
        step(1'b1, 32'h10, 32'h22222222, 1'b1, 1'b1, 4'd6, 1'b1);
        step(1'b1, 32'h10, 32'd0, 1'b0, 1'b1, 4'd7, 1'b1);
        drain();

        // Misaligned write, then read the aligned word.
        step(1'b1, 32'h41, 32'hAAAA5555, 1'b1, 1'b0, 4'd8, 1'b1);
        step(1'b1, 32'h40, 32'd0, 1'b0, 1'b1, 4'd9, 1'b1);
        drain();

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 7, $urandom, $urandom, 1'($urandom), 1'($urandom),
                 TW'($urandom), $urandom_range(0, 9) < 6);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
